// File: rtl/lowent_codebook_engine.sv
// Table-driven low-entropy codebook engine: accumulates symbols into a prefix and emits the matching codeword.
// Optional flush support (flush entries, flush requests, FLUSH_LOOKUP) is built when CODEBOOK_FLUSH_EN is defined.
module lowent_codebook_engine #(
    parameter int SYM_W               = 4,
    parameter int MAX_SYMS            = 16,
    parameter int CODEBOOK_LENGTH_MAX = SYM_W * MAX_SYMS,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int ENTRIES             = 32,
    parameter int ENTRY_AW            = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_we_i,
    output logic                           cfg_ready_o,
    input  logic [ENTRY_AW-1:0]            cfg_addr_i,
    input  logic                           cfg_valid_i,
    input  logic                           cfg_flush_i,
    input  logic [5:0]                     cfg_cnt_i,
    input  logic [CODEBOOK_LENGTH_MAX-1:0] cfg_prefix_i,
    input  logic [5:0]                     cfg_len_i,
    input  logic [ENCODE_DATALENGTH-1:0]   cfg_code_i,
    input  logic                           sym_valid_i,
    output logic                           sym_ready_o,
    input  logic [SYM_W-1:0]               sym_i,
    input  logic                           flush_i,
    output logic                           cw_valid_o,
    input  logic                           cw_ready_i,
    output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
    output logic [5:0]                     cw_length_o,
    output logic                           overflow_o
);

    typedef enum logic [1:0] {ACCEPT, LOOKUP, FLUSH_LOOKUP, EMIT} state_t;

    state_t state, state_n;

    logic [CODEBOOK_LENGTH_MAX-1:0] prefix;
    logic [5:0]                     cnt;

    logic [ENTRIES-1:0]                          tbl_vld;
    logic [ENTRIES-1:0][5:0]                     tbl_cnt;
    logic [ENTRIES-1:0][CODEBOOK_LENGTH_MAX-1:0] tbl_prefix;
    logic [ENTRIES-1:0][5:0]                     tbl_len;
    logic [ENTRIES-1:0][ENCODE_DATALENGTH-1:0]   tbl_code;

    logic [ENTRIES-1:0]  norm_hit, hit_vec;
    logic [ENTRY_AW-1:0] hit_idx;
    logic                any_hit;

    logic acc_sym, clr_pfx, ld_cw, ovf_set, cw_done, cfg_wr;

`ifdef CODEBOOK_FLUSH_EN
    logic [ENTRIES-1:0] tbl_fl;
    logic [ENTRIES-1:0] flush_hit;
`else
    logic unused_flush;
    assign unused_flush = &{1'b0, flush_i, cfg_flush_i};
`endif

    // Ready flags come from registered state only.
    assign sym_ready_o = (state == ACCEPT);
    assign cfg_ready_o = (state == ACCEPT) && (cnt == 6'd0);
    assign cfg_wr      = cfg_we_i && cfg_ready_o;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        logic key_eq;
        assign key_eq = (tbl_cnt[g] == cnt) && (tbl_prefix[g] == prefix);
`ifdef CODEBOOK_FLUSH_EN
        assign norm_hit[g]  = tbl_vld[g] && !tbl_fl[g] && key_eq;
        assign flush_hit[g] = tbl_vld[g] &&  tbl_fl[g] && key_eq;
`else
        assign norm_hit[g]  = tbl_vld[g] && key_eq;
`endif
    end

`ifdef CODEBOOK_FLUSH_EN
    assign hit_vec = (state == FLUSH_LOOKUP) ? flush_hit : norm_hit;
`else
    assign hit_vec = norm_hit;
`endif
    assign any_hit = |hit_vec;

    // Scan downwards so the lowest matching index is the last assignment.
    always_comb begin
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = ENTRY_AW'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ACCEPT;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        acc_sym = 1'b0;
        clr_pfx = 1'b0;
        ld_cw   = 1'b0;
        ovf_set = 1'b0;
        cw_done = 1'b0;
        case (state)
            ACCEPT: begin
                if (sym_valid_i) begin
`ifdef CODEBOOK_FLUSH_EN
                    if (flush_i) begin
                        if (cnt != 6'd0) state_n = FLUSH_LOOKUP;
                    end else begin
                        acc_sym = 1'b1;
                        state_n = LOOKUP;
                    end
`else
                    acc_sym = 1'b1;
                    state_n = LOOKUP;
`endif
                end
            end
            LOOKUP: begin
                if (any_hit) begin
                    ld_cw   = 1'b1;
                    clr_pfx = 1'b1;
                    state_n = EMIT;
                end else begin
                    if (cnt == 6'(MAX_SYMS)) begin
                        ovf_set = 1'b1;
                        clr_pfx = 1'b1;
                    end
                    state_n = ACCEPT;
                end
            end
`ifdef CODEBOOK_FLUSH_EN
            FLUSH_LOOKUP: begin
                clr_pfx = 1'b1;
                if (any_hit) begin
                    ld_cw   = 1'b1;
                    state_n = EMIT;
                end else begin
                    ovf_set = 1'b1;
                    state_n = ACCEPT;
                end
            end
`endif
            EMIT: begin
                if (cw_ready_i) begin
                    cw_done = 1'b1;
                    state_n = ACCEPT;
                end
            end
            default: state_n = ACCEPT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prefix      <= '0;
            cnt         <= '0;
            cw_valid_o  <= 1'b0;
            cw_data_o   <= '0;
            cw_length_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            overflow_o <= ovf_set;
            if (clr_pfx) begin
                prefix <= '0;
                cnt    <= '0;
            end else if (acc_sym) begin
                prefix <= {prefix[CODEBOOK_LENGTH_MAX-SYM_W-1:0], sym_i};
                cnt    <= cnt + 6'd1;
            end
            if (ld_cw) begin
                cw_valid_o  <= 1'b1;
                cw_data_o   <= tbl_code[hit_idx];
                cw_length_o <= tbl_len[hit_idx];
            end else if (cw_done) begin
                cw_valid_o  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl_vld    <= '0;
            tbl_cnt    <= '0;
            tbl_prefix <= '0;
            tbl_len    <= '0;
            tbl_code   <= '0;
        end else if (cfg_wr) begin
            tbl_vld[cfg_addr_i]    <= cfg_valid_i;
            tbl_cnt[cfg_addr_i]    <= cfg_cnt_i;
            tbl_prefix[cfg_addr_i] <= cfg_prefix_i;
            tbl_len[cfg_addr_i]    <= cfg_len_i;
            tbl_code[cfg_addr_i]   <= cfg_code_i;
        end
    end

`ifdef CODEBOOK_FLUSH_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       tbl_fl             <= '0;
        else if (cfg_wr) tbl_fl[cfg_addr_i] <= cfg_flush_i;
    end
`endif

endmodule

// File: tb/tb_lowent_codebook_engine.sv
// Directed bench for lowent_codebook_engine: lookup hits, backpressure, overflow, flush and reset.
module tb_lowent_codebook_engine;

    localparam int SYM_W = 4;
    localparam int MAX_SYMS = 16;
    localparam int CBL = SYM_W * MAX_SYMS;
    localparam int EDL = 21;
    localparam int ENTRIES = 32;
    localparam int AW = 5;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           cfg_we_i = 1'b0;
    logic           cfg_ready_o;
    logic [AW-1:0]  cfg_addr_i = '0;
    logic           cfg_valid_i = 1'b0;
    logic           cfg_flush_i = 1'b0;
    logic [5:0]     cfg_cnt_i = '0;
    logic [CBL-1:0] cfg_prefix_i = '0;
    logic [5:0]     cfg_len_i = '0;
    logic [EDL-1:0] cfg_code_i = '0;
    logic           sym_valid_i = 1'b0;
    logic           sym_ready_o;
    logic [SYM_W-1:0] sym_i = '0;
    logic           flush_i = 1'b0;
    logic           cw_valid_o;
    logic           cw_ready_i = 1'b0;
    logic [EDL-1:0] cw_data_o;
    logic [5:0]     cw_length_o;
    logic           overflow_o;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int ovf_cnt = 0;
    int cwv_cnt = 0;

    lowent_codebook_engine #(
        .SYM_W(SYM_W), .MAX_SYMS(MAX_SYMS), .CODEBOOK_LENGTH_MAX(CBL),
        .ENCODE_DATALENGTH(EDL), .ENTRIES(ENTRIES), .ENTRY_AW(AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_ready_o(cfg_ready_o), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_flush_i(cfg_flush_i), .cfg_cnt_i(cfg_cnt_i),
        .cfg_prefix_i(cfg_prefix_i), .cfg_len_i(cfg_len_i), .cfg_code_i(cfg_code_i),
        .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_i(sym_i),
        .flush_i(flush_i), .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i),
        .cw_data_o(cw_data_o), .cw_length_o(cw_length_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (!rst_i && cw_valid_o && cw_ready_i) xfer_cnt++;
        if (!rst_i && overflow_o) ovf_cnt++;
        if (!rst_i && cw_valid_o) cwv_cnt++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic write_entry(input int addr, input logic v, input logic fl, input int c,
                               input logic [CBL-1:0] p, input int l, input logic [EDL-1:0] code);
        cfg_we_i = 1'b1;
        cfg_addr_i = AW'(addr);
        cfg_valid_i = v;
        cfg_flush_i = fl;
        cfg_cnt_i = 6'(c);
        cfg_prefix_i = p;
        cfg_len_i = 6'(l);
        cfg_code_i = code;
        step();
        cfg_we_i = 1'b0;
    endtask

    // Holds the request until accepted; ends one edge after acceptance.
    task automatic send_sym(input logic [SYM_W-1:0] s, input logic fl);
        int waited = 0;
        sym_valid_i = 1'b1;
        sym_i = s;
        flush_i = fl;
        while (!sym_ready_o && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (!sym_ready_o) begin
            errors++;
            $display("FAIL send_sym_timeout: sym_ready_o=%0b required 1", sym_ready_o);
        end
        step();
        sym_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        checks += 6;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL rst_cw_valid: got %0b want 0", cw_valid_o); end
        if (cw_data_o !== '0) begin errors++; $display("FAIL rst_cw_data: got %0h want 0", cw_data_o); end
        if (cw_length_o !== 6'd0) begin errors++; $display("FAIL rst_cw_len: got %0d want 0", cw_length_o); end
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b want 0", overflow_o); end
        if (sym_ready_o !== 1'b1) begin errors++; $display("FAIL rst_sym_ready: got %0b want 1", sym_ready_o); end
        if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %0b want 1", cfg_ready_o); end
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single();
        write_entry(0, 1'b1, 1'b0, 1, 64'hF, 6, 21'b101101);
        send_sym(4'hF, 1'b0);
        checks += 2;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL single_lookup_valid: got %0b want 0", cw_valid_o); end
        if (sym_ready_o !== 1'b0) begin errors++; $display("FAIL single_lookup_ready: got %0b want 0", sym_ready_o); end
        step();
        checks += 3;
        if (cw_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", cw_valid_o); end
        if (cw_data_o !== 21'h2D) begin errors++; $display("FAIL single_data: got %0h want 2d", cw_data_o); end
        if (cw_length_o !== 6'd6) begin errors++; $display("FAIL single_len: got %0d want 6", cw_length_o); end
        cw_ready_i = 1'b1;
        step();
        cw_ready_i = 1'b0;
        checks += 2;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL single_done_valid: got %0b want 0", cw_valid_o); end
        if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL single_prefix_empty: got %0b want 1", cfg_ready_o); end
    endtask

    task automatic test_multi();
        write_entry(1, 1'b1, 1'b0, 2, 64'h2F, 9, 21'b111010101);
        send_sym(4'h2, 1'b0);
        step();
        checks += 2;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL multi_partial_valid: got %0b want 0", cw_valid_o); end
        if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL multi_partial_cfg_ready: got %0b want 0", cfg_ready_o); end
        send_sym(4'hF, 1'b0);
        step();
        checks += 3;
        if (cw_valid_o !== 1'b1) begin errors++; $display("FAIL multi_valid: got %0b want 1", cw_valid_o); end
        if (cw_data_o !== 21'h1D5) begin errors++; $display("FAIL multi_data: got %0h want 1d5", cw_data_o); end
        if (cw_length_o !== 6'd9) begin errors++; $display("FAIL multi_len: got %0d want 9", cw_length_o); end
        cw_ready_i = 1'b1;
        step();
        cw_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int x0;
        int bad = 0;
        write_entry(3, 1'b1, 1'b0, 1, 64'h7, 5, 21'h11);
        write_entry(7, 1'b1, 1'b0, 1, 64'h7, 6, 21'h22);
        x0 = xfer_cnt;
        send_sym(4'h7, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            if (cw_valid_o !== 1'b1 || cw_data_o !== 21'h11 || cw_length_o !== 6'd5 || sym_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc %0d: valid=%0b data=%0h len=%0d ready=%0b want 1/11/5/0",
                         i, cw_valid_o, cw_data_o, cw_length_o, sym_ready_o);
            end
            step();
        end
        checks++;
        if (bad != 0) errors++;
        cw_ready_i = 1'b1;
        step();
        cw_ready_i = 1'b0;
        step();
        checks += 2;
        if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL bp_xfers: got %0d want 1", xfer_cnt - x0); end
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL bp_after_valid: got %0b want 0", cw_valid_o); end
    endtask

    task automatic test_overflow();
        int o0;
        int v0;
        do_reset();
        o0 = ovf_cnt;
        v0 = cwv_cnt;
        for (int i = 0; i < MAX_SYMS - 1; i++) begin
            send_sym(4'h0, 1'b0);
            step();
        end
        checks++;
        if (ovf_cnt - o0 !== 0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: pulses=%0d ovf=%0b want 0/0", ovf_cnt - o0, overflow_o);
        end
        send_sym(4'h0, 1'b0);
        step();
        checks++;
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", overflow_o); end
        step();
        checks += 4;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_o); end
        if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_cnt_zero: got %0b want 1", cfg_ready_o); end
        if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_once: got %0d want 1", ovf_cnt - o0); end
        if (cwv_cnt - v0 !== 0) begin errors++; $display("FAIL ovf_no_cw: got %0d want 0", cwv_cnt - v0); end
    endtask

`ifdef CODEBOOK_FLUSH_EN
    task automatic test_flush();
        int o0;
        int v0;
        do_reset();
        write_entry(2, 1'b1, 1'b1, 1, 64'h3, 4, 21'hA);
        send_sym(4'h3, 1'b0);
        step();
        checks++;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL flush_entry_nonflush: got %0b want 0", cw_valid_o); end
        send_sym(4'h0, 1'b1);
        step();
        checks += 3;
        if (cw_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid: got %0b want 1", cw_valid_o); end
        if (cw_data_o !== 21'hA) begin errors++; $display("FAIL flush_data: got %0h want a", cw_data_o); end
        if (cw_length_o !== 6'd4) begin errors++; $display("FAIL flush_len: got %0d want 4", cw_length_o); end
        cw_ready_i = 1'b1;
        step();
        cw_ready_i = 1'b0;
        o0 = ovf_cnt;
        v0 = cwv_cnt;
        send_sym(4'h0, 1'b1);
        step();
        step();
        checks += 2;
        if (cwv_cnt - v0 !== 0) begin errors++; $display("FAIL flush_empty_cw: got %0d want 0", cwv_cnt - v0); end
        if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL flush_empty_ovf: got %0d want 0", ovf_cnt - o0); end
    endtask
`else
    task automatic test_flush_ignored();
        do_reset();
        write_entry(0, 1'b1, 1'b1, 1, 64'h5, 3, 21'h5);
        send_sym(4'h5, 1'b1);
        step();
        checks += 3;
        if (cw_valid_o !== 1'b1) begin errors++; $display("FAIL noflush_valid: got %0b want 1", cw_valid_o); end
        if (cw_data_o !== 21'h5) begin errors++; $display("FAIL noflush_data: got %0h want 5", cw_data_o); end
        if (cw_length_o !== 6'd3) begin errors++; $display("FAIL noflush_len: got %0d want 3", cw_length_o); end
        cw_ready_i = 1'b1;
        step();
        cw_ready_i = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_emit();
        int v0;
        do_reset();
        write_entry(0, 1'b1, 1'b0, 1, 64'hF, 6, 21'b101101);
        send_sym(4'hF, 1'b0);
        step();
        checks++;
        if (cw_valid_o !== 1'b1) begin errors++; $display("FAIL rme_pre_valid: got %0b want 1", cw_valid_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks += 2;
        if (cw_valid_o !== 1'b0) begin errors++; $display("FAIL rme_async_valid: got %0b want 0", cw_valid_o); end
        if (cw_data_o !== '0) begin errors++; $display("FAIL rme_async_data: got %0h want 0", cw_data_o); end
        step();
        rst_i = 1'b0;
        step();
        v0 = cwv_cnt;
        send_sym(4'hF, 1'b0);
        step();
        step();
        checks++;
        if (cwv_cnt - v0 !== 0 || cw_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rme_table_cleared: cw cycles=%0d valid=%0b want 0/0", cwv_cnt - v0, cw_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_overflow();
`ifdef CODEBOOK_FLUSH_EN
        test_flush();
`else
        test_flush_ignored();
`endif
        test_reset_mid_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lowent_codebook_engine.md
# lowent_codebook_engine

Parametrised, table-driven low-entropy codebook engine for the hybrid entropy coder. It accumulates input symbols into an active prefix and looks the prefix up in a run-time-loadable codebook table. On a match it emits the codeword with a valid/ready handshake and clears the prefix. It replaces the fixed per-codebook combinational matchers: one instance, loaded per low-entropy code, serves any codebook. Optional flush support terminates a partial prefix at end of segment.

## Interface
Parameters:
- SYM_W, 4, symbol width in bits
- MAX_SYMS, 16, maximum active-prefix depth in symbols
- CODEBOOK_LENGTH_MAX, SYM_W*MAX_SYMS (64), prefix register width
- ENCODE_DATALENGTH, 21, maximum codeword width
- ENTRIES, 32, codebook table depth
- ENTRY_AW, 5, table address width, clog2(ENTRIES)

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_we_i  in  1  table write strobe; honoured only when cfg_ready_o=1.
- cfg_ready_o  out  1  high in ACCEPT with prefix count 0.
- cfg_addr_i  in  ENTRY_AW  entry index.
- cfg_valid_i  in  1  entry valid bit; writing 0 deletes the entry.
- cfg_flush_i  in  1  entry is a flush entry.
- cfg_cnt_i  in  6  prefix length in symbols, 1..MAX_SYMS.
- cfg_prefix_i  in  CODEBOOK_LENGTH_MAX  prefix data, right-aligned, upper bits zero.
- cfg_len_i  in  6  codeword length, 1..ENCODE_DATALENGTH.
- cfg_code_i  in  ENCODE_DATALENGTH  codeword, right-aligned.
- sym_valid_i / sym_ready_o  in/out  1  symbol handshake.
- sym_i  in  SYM_W  symbol.
- flush_i  in  1  qualifies the current sym handshake as a flush request; sym_i is ignored.
- cw_valid_o / cw_ready_i  out/in  1  codeword handshake.
- cw_data_o  out  ENCODE_DATALENGTH  codeword, right-aligned.
- cw_length_o  out  6  codeword length.
- overflow_o  out  1  one-cycle pulse when a prefix reaches MAX_SYMS without a match.

## Operation
- Table storage: registers. Every entry's valid bit clears on reset.
- Prefix update on symbol accept: prefix = (prefix << SYM_W) | sym_i; cnt = cnt + 1. A symbol is accepted when sym_valid_i && sym_ready_o && !flush_i.
- Match condition: entry valid, entry not a flush entry, entry cnt == cnt, and entry prefix == prefix. All entries are compared in parallel; on multiple hits the lowest index wins.
- FSM states: ACCEPT, LOOKUP, FLUSH_LOOKUP, EMIT.
  - ACCEPT: sym_ready_o=1. Symbol accept -> LOOKUP. Flush accept -> FLUSH_LOOKUP if cnt>0; if cnt=0 the request is consumed with no output and the FSM stays in ACCEPT.
  - LOOKUP, hit: latch codeword and length, clear prefix and cnt, go to EMIT.
  - LOOKUP, miss with cnt<MAX_SYMS: go to ACCEPT.
  - LOOKUP, miss with cnt==MAX_SYMS: pulse overflow_o, clear prefix, go to ACCEPT.
  - FLUSH_LOOKUP: same compare with the flush flag required set. Hit -> EMIT. Miss -> pulse overflow_o. Either way the prefix clears.
  - EMIT: cw_valid_o=1 and outputs held stable until cw_ready_i, then go to ACCEPT.
- Config writes take effect on the next cycle and never change a lookup in progress, because writes are only accepted while cfg_ready_o=1.

## Timing
- Reset values: state ACCEPT, prefix 0, cnt 0, cw_valid_o 0, cw_data_o 0, cw_length_o 0, overflow_o 0, all table valid bits 0. sym_ready_o=1 and cfg_ready_o=1 immediately after reset.
- Symbol accepted at edge t: LOOKUP occupies cycle t+1. On a hit, cw_valid_o is high from t+2.
- Throughput: at most one symbol per 2 cycles. Each EMIT adds at least 1 cycle.
- cw_* are registered. sym_ready_o and cfg_ready_o are decoded from registered state only, with no combinational path from any input.
- Reset asserted mid-operation, including in EMIT with cw_valid_o high: all state clears at once and the pending codeword is discarded.

## Configuration
- CODEBOOK_FLUSH_EN defined: flush_i, cfg_flush_i and the FLUSH_LOOKUP state are implemented as described above.
- CODEBOOK_FLUSH_EN undefined: flush_i and cfg_flush_i are ignored and the per-entry flush bit is not stored. Every valid entry is a normal entry, and a sym handshake with flush_i high is treated as an ordinary symbol.

## Test plan
- Single-symbol match: load entry 0 = {cnt 1, prefix 'hF, len 6, code 'b101101}. Send sym F at t -> cw_valid_o at t+2 with cw_data_o='h2D and cw_length_o=6; prefix then empty.
- Multi-symbol match: load {cnt 2, prefix 'h2F, len 9, code 'b111010101}. Send 2 then F -> no output after 2; after F, cw_data_o='h1D5 and cw_length_o=9.
- Backpressure and priority: load identical entries 3 and 7 with different codes. Hold cw_ready_i=0 for 5 cycles -> entry 3's code is held stable, sym_ready_o=0 throughout, and exactly one transfer occurs.
- Overflow: empty table, send 16 symbols 'h0 -> overflow_o pulses once in the cycle after the 16th LOOKUP; cnt returns to 0 and no codeword is emitted.
- Flush (CODEBOOK_FLUSH_EN): load a flush entry {cnt 1, prefix 'h3, len 4, code 'hA}. Send sym 3 then a flush request -> cw 'hA, length 4. A flush request with an empty prefix -> no output, no overflow_o.
- Reset mid-EMIT: assert rst_i while cw_valid_o=1 -> cw_valid_o=0 asynchronously and the table is invalid; a subsequent sym F produces no codeword.
